// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared constants and FSM encoding for the instruction-fetch stage
package stage_if_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } if_state_t;

endpackage

// File: rtl/stage_if_pc_reg.sv
// rtl/stage_if_pc_reg.sv - fetch PC register with hold, +4 advance and redirect load
module stage_if_pc_reg
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_advance,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc_inc
);

    logic [31:0] r_fetch_pc;

    assign o_fetch_pc     = r_fetch_pc;
    assign o_fetch_pc_inc = r_fetch_pc + PC_STEP;

    // Redirect outranks advance; the caller supplies an already word-aligned target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC & WORD_MASK;
        end else if (i_redirect) begin
            r_fetch_pc <= i_redirect_pc;
        end else if (i_advance) begin
            r_fetch_pc <= o_fetch_pc_inc;
        end
    end

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage: request FSM, one-entry skid buffer and IF/ID register
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    if_state_t   r_state;
    if_state_t   w_state_nxt;
    logic        r_active;
    logic [31:0] r_req_addr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    logic [31:0] w_target;
    logic [31:0] w_fetch_pc;
    logic [31:0] w_fetch_pc_inc;
    logic        w_advance;
    logic        w_skid_load;
    logic [31:0] w_req_addr_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_inst_nxt;
    logic        w_valid_nxt;

    assign w_target   = redirect_pc & WORD_MASK;
    assign imem_req   = r_active && (r_state != ST_HOLD);
    assign imem_addr  = r_req_addr;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_valid;

    stage_if_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .i_advance     (w_advance),
        .i_redirect    (redirect),
        .i_redirect_pc (w_target),
        .o_fetch_pc    (w_fetch_pc),
        .o_fetch_pc_inc(w_fetch_pc_inc)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_advance      = 1'b0;
        w_skid_load    = 1'b0;
        w_req_addr_nxt = r_req_addr;
        w_pc_nxt       = r_pc;
        w_inst_nxt     = r_inst;
        w_valid_nxt    = r_valid;

        if (redirect) begin
            w_inst_nxt  = NOP_INST;
            w_valid_nxt = 1'b0;
            // An outstanding request must still complete at its old address before retargeting.
            if ((r_state == ST_FETCH && r_active && !imem_rdy) ||
                (r_state == ST_DROP && !imem_rdy)) begin
                w_state_nxt = ST_DROP;
            end else begin
                w_state_nxt    = ST_FETCH;
                w_req_addr_nxt = w_target;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (r_active && imem_rdy) begin
                        w_advance      = 1'b1;
                        w_req_addr_nxt = w_fetch_pc_inc;
                        if (stall) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_pc_nxt    = r_req_addr;
                            w_inst_nxt  = imem_data;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (!stall) begin
                        w_inst_nxt  = NOP_INST;
                        w_valid_nxt = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_pc_nxt    = r_skid_pc;
                        w_inst_nxt  = r_skid_inst;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (imem_rdy) begin
                        w_state_nxt    = ST_FETCH;
                        w_req_addr_nxt = w_fetch_pc;
                    end
                    if (!stall) begin
                        w_inst_nxt  = NOP_INST;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_active    <= 1'b0;
            r_req_addr  <= RESET_PC & WORD_MASK;
            r_skid_pc   <= 32'h0;
            r_skid_inst <= NOP_INST;
            r_pc        <= 32'h0;
            r_inst      <= NOP_INST;
            r_valid     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_active   <= 1'b1;
            r_req_addr <= w_req_addr_nxt;
            if (w_skid_load) begin
                r_skid_pc   <= r_req_addr;
                r_skid_inst <= imem_data;
            end
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_valid <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - directed bench for the instruction fetch stage
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address so every fetched word is distinct.
    assign imem_data = imem_addr ^ 32'hC0DE_0000;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_addr, input logic e_req,
                           input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_valid);
        chk({tag, ".addr"},  imem_addr, e_addr);
        chk({tag, ".req"},   {31'h0, imem_req}, {31'h0, e_req});
        chk({tag, ".pc"},    pc, e_pc);
        chk({tag, ".inst"},  inst, e_inst);
        chk({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, e_valid});
    endtask

    initial begin
        rst = 1'b1; imem_rdy = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        chk_out("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("first_req", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // Streaming with immediate ready
        tick(); chk_out("stream0", 32'h4,  1'b1, 32'h0, 32'hC0DE_0000, 1'b1);
        tick(); chk_out("stream1", 32'h8,  1'b1, 32'h4, 32'hC0DE_0004, 1'b1);
        tick(); chk_out("stream2", 32'hC,  1'b1, 32'h8, 32'hC0DE_0008, 1'b1);
        tick(); chk_out("stream3", 32'h10, 1'b1, 32'hC, 32'hC0DE_000C, 1'b1);

        // Wait states on 0x10
        imem_rdy = 1'b0;
        tick(); chk_out("wait0", 32'h10, 1'b1, 32'hC, 32'h0, 1'b0);
        tick(); chk_out("wait1", 32'h10, 1'b1, 32'hC, 32'h0, 1'b0);
        tick(); chk_out("wait2", 32'h10, 1'b1, 32'hC, 32'h0, 1'b0);
        imem_rdy = 1'b1;
        tick(); chk_out("wait_done", 32'h14, 1'b1, 32'h10, 32'hC0DE_0010, 1'b1);
        tick(); chk_out("run14", 32'h18, 1'b1, 32'h14, 32'hC0DE_0014, 1'b1);
        tick(); chk_out("run18", 32'h1C, 1'b1, 32'h18, 32'hC0DE_0018, 1'b1);
        tick(); chk_out("run1c", 32'h20, 1'b1, 32'h1C, 32'hC0DE_001C, 1'b1);

        // Stall as 0x20 returns: skid buffer holds it
        stall = 1'b1;
        tick(); chk_out("hold0", 32'h24, 1'b0, 32'h1C, 32'hC0DE_001C, 1'b1);
        tick(); chk_out("hold1", 32'h24, 1'b0, 32'h1C, 32'hC0DE_001C, 1'b1);
        stall = 1'b0;
        tick(); chk_out("unskid", 32'h24, 1'b1, 32'h20, 32'hC0DE_0020, 1'b1);
        tick(); chk_out("after_skid", 32'h28, 1'b1, 32'h24, 32'hC0DE_0024, 1'b1);

        // Redirect with ready discards the response
        redirect = 1'b1; redirect_pc = 32'h40;
        tick(); chk_out("redir_rdy", 32'h40, 1'b1, 32'h24, 32'h0, 1'b0);

        // Redirect to 0x103 while 0x40 is outstanding
        redirect_pc = 32'h103; imem_rdy = 1'b0;
        tick(); chk_out("drop0", 32'h40, 1'b1, 32'h24, 32'h0, 1'b0);
        redirect = 1'b0;
        tick(); chk_out("drop1", 32'h40, 1'b1, 32'h24, 32'h0, 1'b0);
        imem_rdy = 1'b1;
        tick(); chk_out("drop_done", 32'h100, 1'b1, 32'h24, 32'h0, 1'b0);
        tick(); chk_out("target", 32'h104, 1'b1, 32'h100, 32'hC0DE_0100, 1'b1);

        // Redirect and stall together
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick(); chk_out("redir_stall", 32'h200, 1'b1, 32'h100, 32'h0, 1'b0);
        stall = 1'b0; redirect = 1'b0;
        tick(); chk_out("after_rs", 32'h204, 1'b1, 32'h200, 32'hC0DE_0200, 1'b1);

        // Wrap of the fetch PC
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); chk_out("to_top", 32'hFFFF_FFFC, 1'b1, 32'h200, 32'h0, 1'b0);
        redirect = 1'b0;
        tick(); chk_out("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC, 1'b1);
        tick(); chk_out("wrap_next", 32'h4, 1'b1, 32'h0, 32'hC0DE_0000, 1'b1);

        // Redirect while holding a skid entry discards it
        stall = 1'b1;
        tick(); chk_out("hold_b", 32'h8, 1'b0, 32'h0, 32'hC0DE_0000, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h300;
        tick(); chk_out("redir_hold", 32'h300, 1'b1, 32'h0, 32'h0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        tick(); chk_out("after_rh", 32'h304, 1'b1, 32'h300, 32'hC0DE_0300, 1'b1);

        // Reset mid-request abandons the fetch
        imem_rdy = 1'b0;
        tick();
        rst = 1'b1;
        tick(); chk_out("reset2", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0; imem_rdy = 1'b1;
        tick(); chk_out("restart", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
        tick(); chk_out("restart0", 32'h4, 1'b1, 32'h0, 32'hC0DE_0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
